// File: rtl/nios_system_leds.sv
// Avalon-MM LED port: DATA/OUTSET/OUTCLEAR register plus an optional self-clearing STROBE pulse.
// Optional pulse logic is enabled by defining NIOS_SYSTEM_LEDS_PULSE_EN.
module nios_system_leds #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter logic [31:0] PULSE_LEN   = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_port
);

  // Bus handshake: a write is a single-cycle transfer on any edge with
  // chipselect=1 and write_n=0; there is no waitrequest, so no stall is possible.
  logic        wr;
  logic [31:0] data;
  logic [31:0] mask_rd;
  logic [31:0] rd_next;

  assign wr = chipselect & ~write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        2'd0:    data <= writedata;
        2'd2:    data <= data | writedata;
        2'd3:    data <= data & ~writedata;
        default: data <= data;
      endcase
    end
  end

`ifdef NIOS_SYSTEM_LEDS_PULSE_EN
  logic [31:0] mask;
  logic [31:0] count;
  logic        expire;
  logic        strobe_wr;

  assign expire    = (mask != 32'd0) && (count == 32'd0);
  assign strobe_wr = wr && (address == 2'd1) && (writedata != 32'd0);

  // A strobe landing on the expiry edge replaces the old bits instead of extending them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask  <= 32'd0;
      count <= 32'd0;
    end else if (strobe_wr) begin
      mask  <= expire ? writedata : (mask | writedata);
      count <= PULSE_LEN - 32'd1;
    end else if (expire) begin
      mask  <= 32'd0;
    end else if (mask != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  assign mask_rd  = mask;
  assign out_port = data | mask;
`else
  assign mask_rd  = 32'd0;
  assign out_port = data;
`endif

  always_comb begin
    rd_next = 32'd0;
    case (address)
      2'd0:    rd_next = data;
      2'd1:    rd_next = mask_rd;
      default: rd_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule
